ram_access_ctrl: RTL and testbench
==================================

# ram_access_ctrl

Sequencer between the CPU data-memory stage and a single-port 16-bit data RAM: 1024 halfwords, 10-bit halfword address, asynchronous read, write on the rising clock edge when we=1. It converts 32-bit CPU byte/halfword/word loads and stores into one or two RAM cycles. Byte stores are done as read-modify-write. The CPU stalls on `busy` and collects results on the one-cycle `done` pulse.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  access request, sampled only in IDLE
- wr  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- uns  in  1  load extension: 1 = zero-extend, 0 = sign-extend (byte/half only)
- addr  in  11  byte address; halfword index h = addr[10:1]
- wdata  in  32  store data
- rdata  out  32  load result, valid while done=1 and held until the next load completes
- busy  out  1  1 in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  misalignment flag, only meaningful with done
- ram_addr  out  10  RAM halfword address
- ram_d  out  16  RAM write data
- ram_we  out  1  RAM write enable
- ram_q  in  16  RAM read data (combinational from ram_addr)

## Operation
- FSM states: IDLE, RD0, RD1, WR0, WR1, DONE. `ram_we` is decoded from state only: 1 in WR0 and WR1.
- Acceptance: in IDLE with req=1, the rising edge latches wr, size, uns, addr and wdata, then enters the first state of the sequence.
- Sequences:
  - byte or half load: RD0(h) → DONE
  - word load: RD0(h) → RD1(h+1) → DONE; low half at h, little-endian
  - half store: WR0(h, wdata[15:0]) → DONE
  - word store: WR0(h, wdata[15:0]) → WR1(h+1, wdata[31:16]) → DONE
  - byte store: RD0(h), capturing ram_q → WR0(h, merged) → DONE
- Byte merge: addr[0]=0 replaces bits [7:0]; addr[0]=1 replaces bits [15:8]; the other byte is kept from the captured ram_q.
- Byte load lane: addr[0] selects [7:0] or [15:8].
- Extension: result is extended to 32 bits per `uns`. Word loads ignore `uns`.
- Address arithmetic: h+1 is 10-bit and wraps 1023 → 0. This is only reachable when the alignment check is compiled out.
- DONE: done=1 for one cycle, then IDLE. A req during DONE is ignored; it must be held until busy=0.
- Misalignment (alignment check compiled in): half with addr[0]=1, or word with addr[1:0]≠00. The block goes straight to DONE with err=1. No RAM write occurs and rdata is unchanged.

## Timing
- Latency is counted from the accepting edge to the cycle in which done=1:
  - byte/half load: 2
  - half store: 2
  - word load/store: 3
  - byte store: 3
  - misaligned: 1
- Issue interval is latency+1 cycles, because IDLE is re-entered for one cycle before the next acceptance.
- ram_q is sampled on the rising edge that ends RD0 or RD1. ram_addr and ram_d are registered and stable for the whole RD/WR cycle.
- Reset values: state IDLE, busy=0, done=0, err=0, rdata=0, ram_addr=0, ram_d=0, ram_we=0.
- Reset asserted mid-operation drops ram_we immediately with no rollback. A word store interrupted in WR1 leaves the low half written. A byte store interrupted in RD0 writes nothing.

## Configuration
- RAM_ACCESS_ALIGN_CHECK_EN defined: misaligned accesses are trapped as described, and err is live.
- RAM_ACCESS_ALIGN_CHECK_EN undefined: no alignment check and err is tied to 0. Low address bits are ignored: half uses h, word uses h and h+1 with wrap. A byte access is unaffected either way.

## Test plan
- Word store 0x12345678 @0x010, then word load @0x010:
  - RAM[8]=0x5678, RAM[9]=0x1234
  - rdata=0x12345678, done 3 cycles after each accept
- Preload RAM[8]=0xA5C3, byte store 0x7E @0x011 → RAM[8]=0x7EC3; byte load @0x011 with uns=0 → rdata=0x0000007E.
- Byte load @0x010 with RAM[8]=0x7E83:
  - uns=0 → rdata=0xFFFFFF83
  - uns=1 → rdata=0x00000083
  - half load uns=0 → rdata=0x00007E83
- With the macro defined: half store @0x013 → done and err 1 cycle after accept, ram_we never 1, RAM unchanged.
- Without the macro: word store 0xDEADBEEF @0x7FE → RAM[1023]=0xBEEF, RAM[0]=0xDEAD, err=0.
- Word store in flight: rst_n low during WR1 → ram_we=0 at once, all outputs at reset values, RAM[h] holds the new low half, RAM[h+1] is unchanged; the next req is accepted normally after release.

Source files
------------

// File: rtl/ram_access_ctrl_if.sv
// CPU-side bundle of the RAM access sequencer: request fields in, load result and status out.
interface ram_access_ctrl_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output req, wr, size, uns, addr, wdata,
        input  rdata, busy, done, err
    );

    modport slave (
        input  req, wr, size, uns, addr, wdata,
        output rdata, busy, done, err
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// Splits 32-bit CPU byte/half/word accesses into 16-bit single-port RAM cycles.
// Optional misalignment trap: define RAM_ACCESS_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for req, busy=0
// RD0   | reading halfword h (load, or first half of byte read-modify-write)
// RD1   | reading halfword h+1 (upper half of word load)
// WR0   | writing halfword h
// WR1   | writing halfword h+1 (upper half of word store)
// DONE  | one-cycle completion pulse
module ram_access_ctrl (
    input  logic                    clk,
    input  logic                    rst_n,
    ram_access_ctrl_if.slave        cpu,
    output logic [9:0]              ram_addr,
    output logic [15:0]             ram_d,
    output logic                    ram_we,
    input  logic [15:0]             ram_q
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        WR0  = 3'd3,
        WR1  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [10:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [9:0]  ram_addr_q, ram_addr_d;
    logic [15:0] ram_d_q, ram_d_d;

    logic        misalign;
    logic        is_byte_q;
    logic        is_word_q;
    logic [9:0]  h_next;
    logic [7:0]  lane_byte;
    logic [31:0] load_val;
    logic [15:0] merged;

`ifdef RAM_ACCESS_ALIGN_CHECK_EN
    assign misalign = ((cpu.size == 2'b01) && cpu.addr[0]) ||
                      (cpu.size[1] && (cpu.addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // size 11 is reserved and behaves as a word
    assign is_byte_q = (size_q == 2'b00);
    assign is_word_q = size_q[1];
    assign h_next    = addr_q[10:1] + 10'd1;

    assign lane_byte = addr_q[0] ? ram_q[15:8] : ram_q[7:0];
    assign merged    = addr_q[0] ? {wdata_q[7:0], ram_q[7:0]}
                                 : {ram_q[15:8], wdata_q[7:0]};

    always_comb begin
        load_val = 32'd0;
        if (is_byte_q) begin
            load_val = uns_q ? {24'd0, lane_byte}
                             : {{24{lane_byte[7]}}, lane_byte};
        end else begin
            load_val = uns_q ? {16'd0, ram_q}
                             : {{16{ram_q[15]}}, ram_q};
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lo_d       = lo_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        ram_addr_d = ram_addr_q;
        ram_d_d    = ram_d_q;

        case (state_q)
            IDLE: begin
                if (cpu.req) begin
                    wr_d       = cpu.wr;
                    size_d     = cpu.size;
                    uns_d      = cpu.uns;
                    addr_d     = cpu.addr;
                    wdata_d    = cpu.wdata;
                    err_d      = misalign;
                    ram_addr_d = cpu.addr[10:1];
                    if (misalign) begin
                        state_d = DONE;
                    end else if (!cpu.wr || (cpu.size == 2'b00)) begin
                        state_d = RD0;
                    end else begin
                        ram_d_d = cpu.wdata[15:0];
                        state_d = WR0;
                    end
                end
            end
            RD0: begin
                if (wr_q) begin
                    // byte store: write back the read halfword with one lane replaced
                    ram_d_d = merged;
                    state_d = WR0;
                end else if (is_word_q) begin
                    lo_d       = ram_q;
                    ram_addr_d = h_next;
                    state_d    = RD1;
                end else begin
                    rdata_d = load_val;
                    state_d = DONE;
                end
            end
            RD1: begin
                rdata_d = {ram_q, lo_q};
                state_d = DONE;
            end
            WR0: begin
                if (is_word_q && !is_byte_q) begin
                    ram_addr_d = h_next;
                    ram_d_d    = wdata_q[31:16];
                    state_d    = WR1;
                end else begin
                    state_d = DONE;
                end
            end
            WR1: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= 11'd0;
            wdata_q    <= 32'd0;
            lo_q       <= 16'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
            ram_addr_q <= 10'd0;
            ram_d_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lo_q       <= lo_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            ram_addr_q <= ram_addr_d;
            ram_d_q    <= ram_d_d;
        end
    end

    // write enable is a pure state decode so reset removes it without waiting for a clock
    assign ram_we    = (state_q == WR0) || (state_q == WR1);
    assign ram_addr  = ram_addr_q;
    assign ram_d     = ram_d_q;
    assign cpu.busy  = (state_q != IDLE);
    assign cpu.done  = (state_q == DONE);
    assign cpu.err   = err_q;
    assign cpu.rdata = rdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed, table-driven bench for ram_access_ctrl with a behavioural 1024x16 RAM.
module tb_ram_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic [9:0]  ram_addr;
    logic [15:0] ram_d;
    logic        ram_we;
    logic [15:0] ram_q;

    ram_access_ctrl_if cpu ();

    ram_access_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu      (cpu),
        .ram_addr (ram_addr),
        .ram_d    (ram_d),
        .ram_we   (ram_we),
        .ram_q    (ram_q)
    );

    logic [15:0] mem [1024];
    logic        pre_we;
    logic [9:0]  pre_i;
    logic [15:0] pre_v;
    int          we_cnt;

    assign ram_q = mem[ram_addr];

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_d;
        else if (pre_we) mem[pre_i] <= pre_v;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) we_cnt <= we_cnt;
        else if (ram_we) we_cnt <= we_cnt + 1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [9:0] i, input logic [15:0] v);
        pre_we = 1'b1;
        pre_i  = i;
        pre_v  = v;
        @(posedge clk);
        #1 pre_we = 1'b0;
        @(negedge clk);
    endtask

    // called at a negedge; returns at a negedge one cycle after done
    task automatic access(input logic w, input logic [1:0] sz, input logic u,
                          input logic [10:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic e);
        int n;
        n = 0;
        while (cpu.busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        cpu.req   = 1'b1;
        cpu.wr    = w;
        cpu.size  = sz;
        cpu.uns   = u;
        cpu.addr  = a;
        cpu.wdata = d;
        @(posedge clk);
        #1 cpu.req = 1'b0;
        lat = 1;
        @(negedge clk);
        while (cpu.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = cpu.rdata;
        e  = cpu.err;
        @(negedge clk);
        chk("done_pulse_end", {30'd0, cpu.done, cpu.busy}, 32'd0);
    endtask

    typedef struct {
        logic        pre_en;
        logic [9:0]  pre_i;
        logic [15:0] pre_v;
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [10:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_we;
        int          rn;
        logic [9:0]  ri0;
        logic [15:0] rv0;
        logic [9:0]  ri1;
        logic [15:0] rv1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic pe, input logic [9:0] pi, input logic [15:0] pv,
                                input logic w, input logic [1:0] sz, input logic u,
                                input logic [10:0] a, input logic [31:0] d,
                                input logic [31:0] erd, input int elat, input int ewe,
                                input int rn, input logic [9:0] ri0, input logic [15:0] rv0,
                                input logic [9:0] ri1, input logic [15:0] rv1);
        vec_t v;
        v.pre_en = pe;  v.pre_i = pi;  v.pre_v = pv;
        v.w = w;  v.sz = sz;  v.u = u;  v.a = a;  v.d = d;
        v.exp_rd = erd;  v.exp_lat = elat;  v.exp_we = ewe;
        v.rn = rn;  v.ri0 = ri0;  v.rv0 = rv0;  v.ri1 = ri1;  v.rv1 = rv1;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e;
        int          wc0;

        //             pre          w  sz    u  addr    wdata          exp_rdata     lat we rn ri0 rv0     ri1 rv1
        vecs.push_back(mk(0, 0, 0,      1, 2'b10, 0, 11'h010, 32'h12345678, 32'h00000000, 3, 2, 2, 8,  16'h5678, 9,  16'h1234));
        vecs.push_back(mk(0, 0, 0,      0, 2'b10, 0, 11'h010, 32'h0,        32'h12345678, 3, 0, 0, 0,  0,        0,  0));
        vecs.push_back(mk(1, 8, 16'hA5C3, 1, 2'b00, 0, 11'h011, 32'h0000007E, 32'h12345678, 3, 1, 1, 8,  16'h7EC3, 0,  0));
        vecs.push_back(mk(0, 0, 0,      0, 2'b00, 0, 11'h011, 32'h0,        32'h0000007E, 2, 0, 0, 0,  0,        0,  0));
        vecs.push_back(mk(1, 8, 16'h7E83, 0, 2'b00, 0, 11'h010, 32'h0,      32'hFFFFFF83, 2, 0, 0, 0,  0,        0,  0));
        vecs.push_back(mk(0, 0, 0,      0, 2'b00, 1, 11'h010, 32'h0,        32'h00000083, 2, 0, 0, 0,  0,        0,  0));
        vecs.push_back(mk(0, 0, 0,      0, 2'b01, 0, 11'h010, 32'h0,        32'h00007E83, 2, 0, 0, 0,  0,        0,  0));
        vecs.push_back(mk(1, 8, 16'h8001, 0, 2'b01, 1, 11'h010, 32'h0,      32'h00008001, 2, 0, 0, 0,  0,        0,  0));
        vecs.push_back(mk(0, 0, 0,      0, 2'b01, 0, 11'h010, 32'h0,        32'hFFFF8001, 2, 0, 0, 0,  0,        0,  0));
        vecs.push_back(mk(0, 0, 0,      0, 2'b00, 0, 11'h011, 32'h0,        32'hFFFFFF80, 2, 0, 0, 0,  0,        0,  0));
        vecs.push_back(mk(0, 0, 0,      0, 2'b00, 1, 11'h011, 32'h0,        32'h00000080, 2, 0, 0, 0,  0,        0,  0));
        vecs.push_back(mk(0, 0, 0,      1, 2'b01, 0, 11'h030, 32'hFFFFBEEF, 32'h00000080, 2, 1, 1, 24, 16'hBEEF, 0,  0));
        vecs.push_back(mk(0, 0, 0,      1, 2'b00, 0, 11'h031, 32'h000000AB, 32'h00000080, 3, 1, 1, 24, 16'hABEF, 0,  0));
        vecs.push_back(mk(0, 0, 0,      1, 2'b00, 0, 11'h030, 32'h000000CD, 32'h00000080, 3, 1, 1, 24, 16'hABCD, 0,  0));
        vecs.push_back(mk(0, 0, 0,      1, 2'b11, 0, 11'h040, 32'h0BADF00D, 32'h00000080, 3, 2, 2, 32, 16'hF00D, 33, 16'h0BAD));
        vecs.push_back(mk(0, 0, 0,      0, 2'b11, 1, 11'h040, 32'h0,        32'h0BADF00D, 3, 0, 0, 0,  0,        0,  0));
        vecs.push_back(mk(0, 0, 0,      0, 2'b10, 0, 11'h040, 32'h0,        32'h0BADF00D, 3, 0, 0, 0,  0,        0,  0));
        vecs.push_back(mk(1, 25, 16'h8000, 0, 2'b10, 1, 11'h030, 32'h0,     32'h8000ABCD, 3, 0, 0, 0,  0,        0,  0));

        pre_we    = 1'b0;
        pre_i     = '0;
        pre_v     = '0;
        we_cnt    = 0;
        cpu.req   = 1'b0;
        cpu.wr    = 1'b0;
        cpu.size  = 2'b00;
        cpu.uns   = 1'b0;
        cpu.addr  = '0;
        cpu.wdata = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",     {31'd0, cpu.busy}, 32'd0);
        chk("rst_done",     {31'd0, cpu.done}, 32'd0);
        chk("rst_err",      {31'd0, cpu.err},  32'd0);
        chk("rst_rdata",    cpu.rdata,         32'd0);
        chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
        chk("rst_ram_d",    {16'd0, ram_d},    32'd0);
        chk("rst_ram_we",   {31'd0, ram_we},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].pre_en) preload(vecs[i].pre_i, vecs[i].pre_v);
            wc0 = we_cnt;
            access(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].d, lat, rd, e);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d err", i), {31'd0, e}, 32'd0);
            chk($sformatf("v%0d we_cycles", i), 32'(we_cnt - wc0), 32'(vecs[i].exp_we));
            if (vecs[i].rn >= 1)
                chk($sformatf("v%0d ram[%0d]", i, vecs[i].ri0), {16'd0, mem[vecs[i].ri0]}, {16'd0, vecs[i].rv0});
            if (vecs[i].rn >= 2)
                chk($sformatf("v%0d ram[%0d]", i, vecs[i].ri1), {16'd0, mem[vecs[i].ri1]}, {16'd0, vecs[i].rv1});
        end

`ifdef RAM_ACCESS_ALIGN_CHECK_EN
        wc0 = we_cnt;
        access(1'b1, 2'b01, 1'b0, 11'h013, 32'h00005555, lat, rd, e);
        chk("mis_half_st latency", 32'(lat), 32'd1);
        chk("mis_half_st err", {31'd0, e}, 32'd1);
        chk("mis_half_st we_cycles", 32'(we_cnt - wc0), 32'd0);
        chk("mis_half_st ram[9]", {16'd0, mem[9]}, 32'h00001234);
        chk("mis_half_st rdata", rd, 32'h8000ABCD);
        access(1'b0, 2'b10, 1'b0, 11'h012, 32'h0, lat, rd, e);
        chk("mis_word_ld latency", 32'(lat), 32'd1);
        chk("mis_word_ld err", {31'd0, e}, 32'd1);
        chk("mis_word_ld rdata", rd, 32'h8000ABCD);
`else
        wc0 = we_cnt;
        access(1'b1, 2'b10, 1'b0, 11'h7FE, 32'hDEADBEEF, lat, rd, e);
        chk("wrap_st latency", 32'(lat), 32'd3);
        chk("wrap_st err", {31'd0, e}, 32'd0);
        chk("wrap_st we_cycles", 32'(we_cnt - wc0), 32'd2);
        chk("wrap_st ram[1023]", {16'd0, mem[1023]}, 32'h0000BEEF);
        chk("wrap_st ram[0]", {16'd0, mem[0]}, 32'h0000DEAD);
        access(1'b1, 2'b01, 1'b0, 11'h013, 32'h00005555, lat, rd, e);
        chk("odd_half_st latency", 32'(lat), 32'd2);
        chk("odd_half_st err", {31'd0, e}, 32'd0);
        chk("odd_half_st ram[9]", {16'd0, mem[9]}, 32'h00005555);
`endif

        // reset during WR1 of a word store
        preload(10'd16, 16'h1111);
        preload(10'd17, 16'h2222);
        cpu.req   = 1'b1;
        cpu.wr    = 1'b1;
        cpu.size  = 2'b10;
        cpu.uns   = 1'b0;
        cpu.addr  = 11'h020;
        cpu.wdata = 32'hCAFEBABE;
        @(posedge clk);
        #1 cpu.req = 1'b0;
        @(posedge clk);
        #1;
        chk("wr1 ram_we", {31'd0, ram_we}, 32'd1);
        chk("wr1 ram_addr", {22'd0, ram_addr}, 32'd17);
        rst_n = 1'b0;
        #1;
        chk("mid_rst ram_we",   {31'd0, ram_we},   32'd0);
        chk("mid_rst busy",     {31'd0, cpu.busy}, 32'd0);
        chk("mid_rst done",     {31'd0, cpu.done}, 32'd0);
        chk("mid_rst err",      {31'd0, cpu.err},  32'd0);
        chk("mid_rst rdata",    cpu.rdata,         32'd0);
        chk("mid_rst ram_addr", {22'd0, ram_addr}, 32'd0);
        chk("mid_rst ram_d",    {16'd0, ram_d},    32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst ram[16]", {16'd0, mem[16]}, 32'h0000BABE);
        chk("mid_rst ram[17]", {16'd0, mem[17]}, 32'h00002222);
        rst_n = 1'b1;
        @(negedge clk);
        access(1'b0, 2'b10, 1'b0, 11'h020, 32'h0, lat, rd, e);
        chk("post_rst latency", 32'(lat), 32'd3);
        chk("post_rst rdata", rd, 32'h2222BABE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
